// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared width, reset defaults, channel config type and index-width helper
package clk_div_pkg;
  localparam int W = 8;
  localparam int PERIOD_RST_DEF = 20;
  localparam int HIGH_RST_DEF = 10;
  typedef struct packed {
    logic [W-1:0] period;
    logic [W-1:0] high;
  } cfg_t;
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: control/write bus and divided outputs of the divider bank
interface clk_div_bank_if import clk_div_pkg::*; #(
  parameter int NCH = 2
);
  logic [NCH-1:0] en;
  logic sync;
  logic wr_en;
  logic [chw(NCH)-1:0] wr_ch;
  logic [W-1:0] wr_period;
  logic [W-1:0] wr_high;
  logic [NCH-1:0] oClk;
  logic [NCH-1:0] oTick;
  logic [NCH-1:0] oLoaded;
  modport master (
    output en, sync, wr_en, wr_ch, wr_period, wr_high,
    input oClk, oTick, oLoaded
  );
  modport slave (
    input en, sync, wr_en, wr_ch, wr_period, wr_high,
    output oClk, oTick, oLoaded
  );
endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel; new config only lands on a cnt=0 restart so oClk never glitches
module clk_div_chan import clk_div_pkg::*; #(
  parameter int PERIOD_RST = PERIOD_RST_DEF,
  parameter int HIGH_RST = HIGH_RST_DEF
) (
  input  logic clk100MHz,
  input  logic rst,
  input  logic en,
  input  logic sync,
  input  logic wr,
  input  cfg_t wr_cfg,
  output logic oClk,
  output logic oTick,
  output logic oLoaded
);
  cfg_t act, act_n, pen;
  logic [W-1:0] cnt, cnt_n;
  logic run, pend, pend_n, wrap, restart, bypass, take_pend, load_n;
  always_comb begin
    wrap = run && cnt == act.period;
    restart = !en || !run || sync || wrap;
    // a write landing on a restart goes straight to active, except under sync
    bypass = wr && (!en || !run || (wrap && !sync));
    take_pend = pend && restart;
    act_n = bypass ? wr_cfg : take_pend ? pen : act;
    pend_n = bypass ? 1'b0 : wr ? 1'b1 : take_pend ? 1'b0 : pend;
    load_n = bypass || take_pend;
    cnt_n = restart ? '0 : cnt + W'(1);
  end
  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      run <= 1'b0;
      cnt <= '0;
      act <= '{period: W'(PERIOD_RST), high: W'(HIGH_RST)};
      pen <= '0;
      pend <= 1'b0;
      oClk <= 1'b0;
      oTick <= 1'b0;
      oLoaded <= 1'b0;
    end else begin
      run <= en;
      cnt <= cnt_n;
      act <= act_n;
      if (wr) pen <= wr_cfg;
      pend <= pend_n;
      oClk <= en && cnt_n < act_n.high;
      oTick <= en && cnt_n == '0;
      oLoaded <= load_n;
    end
  end
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NCH programmable integer clock dividers sharing one write port and sync
module clk_div_bank import clk_div_pkg::*; #(
  parameter int NCH = 2,
  parameter int PERIOD_RST = PERIOD_RST_DEF,
  parameter int HIGH_RST = HIGH_RST_DEF
) (
  input logic clk100MHz,
  input logic rst,
  clk_div_bank_if.slave bus
);
  localparam int CW = chw(NCH);
  cfg_t wr_cfg;
  logic [NCH-1:0] clk_v, tick_v, load_v;
  assign wr_cfg = '{period: bus.wr_period, high: bus.wr_high};
  assign bus.oClk = clk_v;
  assign bus.oTick = tick_v;
  assign bus.oLoaded = load_v;
  // indices >= NCH match no instance, so such writes are dropped
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_chan #(.PERIOD_RST(PERIOD_RST), .HIGH_RST(HIGH_RST)) u_ch (
      .clk100MHz(clk100MHz),
      .rst(rst),
      .en(bus.en[i]),
      .sync(bus.sync),
      .wr(bus.wr_en && bus.wr_ch == CW'(i)),
      .wr_cfg(wr_cfg),
      .oClk(clk_v[i]),
      .oTick(tick_v[i]),
      .oLoaded(load_v[i])
    );
  end
endmodule
